// File: rtl/mem_bus_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter onto one memory bus master.
// Optional `MEM_ARB_ROUND_ROBIN_EN selects round-robin ties; default favours the data port.
module mem_bus_arbiter #(
    parameter int unsigned MAX_WAIT     = 255,  // must be >= 1
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,

    input  logic [31:0] d_address,
    input  logic [3:0]  d_byteenable,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,

    output logic [31:0] m_address,
    output logic [3:0]  m_byteenable,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,

    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDATA, DONE} state_t;

    localparam int unsigned     CNT_W     = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t           state;
    logic             gnt_d;
    logic             op_write;
    logic [CNT_W-1:0] wait_cnt;

    logic i_req;
    logic d_req;
    logic pick_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_gnt_d;
    // On a tie the port that did not win last time goes next.
    assign pick_d = d_req && (!i_req || !last_gnt_d);
`else
    assign pick_d = d_req;
`endif

    // The m_* registers double as the latched copy of the granted request.
    always_ff @(posedge clk) begin
        // NOTE: every state register uses <= so all of them update from the same pre-edge values.
        if (!rst_n) begin
            state         <= IDLE;
            gnt_d         <= 1'b0;
            op_write      <= 1'b0;
            wait_cnt      <= '0;
            m_address     <= '0;
            m_byteenable  <= '0;
            m_writedata   <= '0;
            m_read        <= 1'b0;
            m_write       <= 1'b0;
            i_waitrequest <= 1'b1;
            d_waitrequest <= 1'b1;
            i_readdata    <= '0;
            d_readdata    <= '0;
            timeout_err   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_gnt_d    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state    <= ISSUE;
                        gnt_d    <= pick_d;
                        wait_cnt <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_gnt_d <= pick_d;
`endif
                        if (pick_d) begin
                            m_address    <= d_address;
                            m_byteenable <= d_byteenable;
                            m_writedata  <= d_writedata;
                            op_write     <= d_write;
                            m_read       <= !d_write;
                            m_write      <= d_write;
                        end else begin
                            m_address    <= i_address;
                            m_byteenable <= 4'b1111;
                            m_writedata  <= '0;
                            op_write     <= 1'b0;
                            m_read       <= 1'b1;
                            m_write      <= 1'b0;
                        end
                    end
                end

                ISSUE: begin
                    if (!m_waitrequest) begin
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                        if (op_write) begin
                            state <= DONE;
                            if (gnt_d) d_waitrequest <= 1'b0;
                            else       i_waitrequest <= 1'b0;
                        end else begin
                            state <= RDATA;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        // This edge closes the MAX_WAIT-th stall cycle: abandon the access.
                        m_read      <= 1'b0;
                        m_write     <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= DONE;
                        if (gnt_d) begin
                            d_waitrequest <= 1'b0;
                            if (!op_write) d_readdata <= TIMEOUT_DATA;
                        end else begin
                            i_waitrequest <= 1'b0;
                            i_readdata    <= TIMEOUT_DATA;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                RDATA: begin
                    state <= DONE;
                    if (gnt_d) begin
                        d_readdata    <= m_readdata;
                        d_waitrequest <= 1'b0;
                    end else begin
                        i_readdata    <= m_readdata;
                        i_waitrequest <= 1'b0;
                    end
                end

                DONE: begin
                    state         <= IDLE;
                    i_waitrequest <= 1'b1;
                    d_waitrequest <= 1'b1;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized
// transactions scored against a transaction-level model and a behavioural slave.
module tb_mem_bus_arbiter;

    localparam int unsigned MAXW = 8;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_address;
    logic        i_read;
    logic        i_waitrequest;
    logic [31:0] i_readdata;
    logic [31:0] d_address;
    logic [3:0]  d_byteenable;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_writedata;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic [31:0] m_address;
    logic [3:0]  m_byteenable;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.MAX_WAIT(MAXW), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_address(i_address), .i_read(i_read),
        .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
        .d_address(d_address), .d_byteenable(d_byteenable),
        .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
        .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .m_address(m_address), .m_byteenable(m_byteenable),
        .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .timeout_err(timeout_err)
    );

    // Behavioural slave: stalls stall_cfg cycles per access, read data one cycle after acceptance.
    int          stall_cfg = 0;
    bit          stuck     = 1'b0;
    int          busy      = 0;
    bit          p_act = 1'b0, p_wait = 1'b0, p_wr = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    logic [3:0]  p_be = '0;
    int          acc_cnt = 0;
    logic [31:0] acc_addr = '0, acc_wdata = '0;
    logic [3:0]  acc_be = '0;
    bit          acc_wr = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC00000) return 32'h24020005;
        return (a * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    initial begin
        m_waitrequest = 1'b0;
        m_readdata    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (p_act && !p_wait) begin
                acc_cnt++;
                acc_addr  = p_addr;
                acc_be    = p_be;
                acc_wdata = p_wdata;
                acc_wr    = p_wr;
                m_readdata = p_wr ? $urandom : mem_word(p_addr);
            end else begin
                m_readdata = $urandom;
            end
            if (m_read || m_write) begin
                busy = p_act ? busy + 1 : 0;
                m_waitrequest = stuck || (busy < stall_cfg);
            end else begin
                busy = 0;
                m_waitrequest = 1'b0;
            end
            p_act   = m_read || m_write;
            p_wait  = m_waitrequest;
            p_wr    = m_write;
            p_addr  = m_address;
            p_be    = m_byteenable;
            p_wdata = m_writedata;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0;
        d_byteenable = '0; d_writedata = '0;
    endtask

    task automatic do_reset();
        clear_req();
        stall_cfg = 0;
        stuck = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_req();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({m_read, m_write} !== 2'b00) begin
            errors++; $display("FAIL reset_strobes: got %b expected 00", {m_read, m_write});
        end
        checks++;
        if ({m_address, m_writedata, m_byteenable} !== 68'h0) begin
            errors++; $display("FAIL reset_bus: got %h/%h/%h expected 0", m_address, m_writedata, m_byteenable);
        end
        checks++;
        if ({i_waitrequest, d_waitrequest} !== 2'b11) begin
            errors++; $display("FAIL reset_wait: got %b expected 11", {i_waitrequest, d_waitrequest});
        end
        checks++;
        if ({i_readdata, d_readdata, timeout_err} !== 65'h0) begin
            errors++; $display("FAIL reset_rdata: got %h/%h err=%b expected 0", i_readdata, d_readdata, timeout_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        do_reset();
        i_address = 32'hBFC00000;
        i_read = 1'b1;
        step();
        checks++;
        if ({m_read, m_write, m_byteenable, m_address} !== {2'b10, 4'b1111, 32'hBFC00000}) begin
            errors++; $display("FAIL fetch_issue: got rd=%b wr=%b be=%b a=%h expected rd=1 wr=0 be=1111 a=bfc00000",
                               m_read, m_write, m_byteenable, m_address);
        end
        step();
        checks++;
        if (i_waitrequest !== 1'b1) begin
            errors++; $display("FAIL fetch_stall_c2: got %b expected 1", i_waitrequest);
        end
        step();
        checks++;
        if ({i_waitrequest, d_waitrequest, i_readdata} !== {2'b01, 32'h24020005}) begin
            errors++; $display("FAIL fetch_done: got iw=%b dw=%b data=%h expected iw=0 dw=1 data=24020005",
                               i_waitrequest, d_waitrequest, i_readdata);
        end
        i_read = 1'b0;
        step();
    endtask

    task automatic test_store();
        int pre;
        do_reset();
        pre = acc_cnt;
        d_write = 1'b1;
        d_address = 32'hBFC00010;
        d_byteenable = 4'b0011;
        d_writedata = 32'h0000ABCD;
        step();
        checks++;
        if ({m_write, m_read, m_address, m_byteenable, m_writedata} !==
            {2'b10, 32'hBFC00010, 4'b0011, 32'h0000ABCD}) begin
            errors++; $display("FAIL store_issue: got wr=%b rd=%b a=%h be=%b d=%h expected wr=1 rd=0 a=bfc00010 be=0011 d=0000abcd",
                               m_write, m_read, m_address, m_byteenable, m_writedata);
        end
        step();
        checks++;
        if ({d_waitrequest, i_waitrequest, m_write} !== 3'b010) begin
            errors++; $display("FAIL store_done: got dw=%b iw=%b wr=%b expected dw=0 iw=1 wr=0",
                               d_waitrequest, i_waitrequest, m_write);
        end
        checks++;
        if (acc_cnt !== pre + 1 || acc_wr !== 1'b1 || acc_wdata !== 32'h0000ABCD || acc_be !== 4'b0011) begin
            errors++; $display("FAIL store_bus: got n=%0d wr=%b d=%h be=%b expected n=%0d wr=1 d=0000abcd be=0011",
                               acc_cnt - pre, acc_wr, acc_wdata, acc_be, 1);
        end
        d_write = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit got_d;
        bit exp_d;
        do_reset();
        i_address = 32'h00000100;
        d_address = 32'h00000200;
        i_read = 1'b1;
        d_read = 1'b1;
        cyc = 0;
        for (int k = 0; k < 3; k++) begin
            do begin
                step();
                cyc++;
            end while (i_waitrequest && d_waitrequest && cyc < 40);
            exp_d = RR ? (k != 1) : 1'b1;
            got_d = !d_waitrequest;
            checks++;
            if (cyc !== 3 + 4 * k) begin
                errors++; $display("FAIL tie_cycle%0d: got %0d expected %0d", k, cyc, 3 + 4 * k);
            end
            checks++;
            if ({got_d, !i_waitrequest} !== {exp_d, !exp_d}) begin
                errors++; $display("FAIL tie_grant%0d: got d=%b i=%b expected d=%b", k, got_d, !i_waitrequest, exp_d);
            end
            checks++;
            if (exp_d ? (d_readdata !== mem_word(32'h200)) : (i_readdata !== mem_word(32'h100))) begin
                errors++; $display("FAIL tie_data%0d: got %h/%h expected %h", k, i_readdata, d_readdata,
                                   exp_d ? mem_word(32'h200) : mem_word(32'h100));
            end
        end
        clear_req();
        step();
    endtask

    task automatic test_stall();
        do_reset();
        stall_cfg = 4;
        d_read = 1'b1;
        d_address = 32'h00001000;
        for (int c = 1; c <= 7; c++) begin
            step();
            checks++;
            if (c <= 5) begin
                if ({m_read, d_waitrequest} !== 2'b11) begin
                    errors++; $display("FAIL stall_issue_c%0d: got rd=%b dw=%b expected 11", c, m_read, d_waitrequest);
                end
            end else if (c == 6) begin
                if ({m_read, d_waitrequest} !== 2'b01) begin
                    errors++; $display("FAIL stall_rdata: got rd=%b dw=%b expected 01", m_read, d_waitrequest);
                end
            end else begin
                if ({d_waitrequest, timeout_err, d_readdata} !== {2'b00, mem_word(32'h1000)}) begin
                    errors++; $display("FAIL stall_done: got dw=%b err=%b data=%h expected dw=0 err=0 data=%h",
                                       d_waitrequest, timeout_err, d_readdata, mem_word(32'h1000));
                end
            end
        end
        clear_req();
        stall_cfg = 0;
        step();
    endtask

    task automatic test_random();
        bit last_d;
        do_reset();
        last_d = 1'b0;
        for (int t = 0; t < 30; t++) begin
            int kind, dop, stalls, cyc, exp_lat, pre;
            bit want_i, want_d, win_d, exp_wr;
            logic [31:0] exp_addr;
            logic [3:0]  exp_be;
            kind   = $urandom_range(0, 2);
            dop    = $urandom_range(0, 2);
            stalls = $urandom_range(0, 3);
            want_i = (kind != 1);
            want_d = (kind != 0);
            stall_cfg    = stalls;
            i_address    = $urandom;
            d_address    = $urandom;
            d_byteenable = 4'($urandom);
            d_writedata  = $urandom;
            i_read  = want_i;
            d_read  = want_d && (dop != 1);
            d_write = want_d && (dop != 0);
            win_d    = want_d && (!want_i || !RR || !last_d);
            last_d   = win_d;
            exp_wr   = win_d && (dop != 0);
            exp_lat  = 1 + stalls + (exp_wr ? 1 : 2);
            exp_addr = win_d ? d_address : i_address;
            exp_be   = win_d ? d_byteenable : 4'b1111;
            pre = acc_cnt;
            cyc = 0;
            do begin
                step();
                cyc++;
            end while (i_waitrequest && d_waitrequest && cyc < 30);
            checks++;
            if ({!d_waitrequest, !i_waitrequest} !== {win_d, !win_d}) begin
                errors++; $display("FAIL rand%0d_grant: got d=%b i=%b expected d=%b", t, !d_waitrequest, !i_waitrequest, win_d);
            end
            checks++;
            if (cyc !== exp_lat) begin
                errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", t, cyc, exp_lat);
            end
            checks++;
            if (acc_cnt !== pre + 1 || acc_addr !== exp_addr || acc_be !== exp_be || acc_wr !== exp_wr ||
                (exp_wr && acc_wdata !== d_writedata)) begin
                errors++; $display("FAIL rand%0d_bus: got n=%0d a=%h be=%b wr=%b d=%h expected n=1 a=%h be=%b wr=%b d=%h",
                                   t, acc_cnt - pre, acc_addr, acc_be, acc_wr, acc_wdata,
                                   exp_addr, exp_be, exp_wr, d_writedata);
            end
            if (!exp_wr) begin
                checks++;
                if ((win_d ? d_readdata : i_readdata) !== mem_word(exp_addr)) begin
                    errors++; $display("FAIL rand%0d_rdata: got %h expected %h", t,
                                       win_d ? d_readdata : i_readdata, mem_word(exp_addr));
                end
            end
            clear_req();
            step();
        end
        stall_cfg = 0;
    endtask

    task automatic test_timeout();
        do_reset();
        stuck = 1'b1;
        d_read = 1'b1;
        d_address = 32'h00002000;
        for (int c = 1; c <= 9; c++) begin
            step();
            checks++;
            if (c <= 8) begin
                if ({m_read, d_waitrequest} !== 2'b11) begin
                    errors++; $display("FAIL timeout_issue_c%0d: got rd=%b dw=%b expected 11", c, m_read, d_waitrequest);
                end
            end else begin
                if ({m_read, d_waitrequest, timeout_err, d_readdata} !== {3'b001, 32'hDEADBEEF}) begin
                    errors++; $display("FAIL timeout_done: got rd=%b dw=%b err=%b data=%h expected rd=0 dw=0 err=1 data=deadbeef",
                                       m_read, d_waitrequest, timeout_err, d_readdata);
                end
            end
        end
        clear_req();
        stuck = 1'b0;
        repeat (5) step();
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky: got %b expected 1", timeout_err);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL timeout_clear: got %b expected 0", timeout_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        d_read = 1'b1;
        d_address = 32'h00000040;
        repeat (3) step();
        checks++;
        if ({d_waitrequest, d_readdata} !== {1'b0, mem_word(32'h40)}) begin
            errors++; $display("FAIL midrst_pre: got dw=%b data=%h expected dw=0 data=%h",
                               d_waitrequest, d_readdata, mem_word(32'h40));
        end
        d_read = 1'b0;
        step();
        d_read = 1'b1;
        d_address = 32'h00000080;
        step();
        step();
        checks++;
        if ({m_read, d_waitrequest} !== 2'b01) begin
            errors++; $display("FAIL midrst_rdata: got rd=%b dw=%b expected 01", m_read, d_waitrequest);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if ({m_read, i_waitrequest, d_waitrequest, i_readdata, d_readdata, m_address} !== {3'b011, 96'h0}) begin
            errors++; $display("FAIL midrst_state: got rd=%b iw=%b dw=%b id=%h dd=%h a=%h expected rd=0 iw=1 dw=1 zeros",
                               m_read, i_waitrequest, d_waitrequest, i_readdata, d_readdata, m_address);
        end
        d_read = 1'b0;
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if ({m_read, d_waitrequest} !== 2'b01) begin
            errors++; $display("FAIL midrst_idle: got rd=%b dw=%b expected 01", m_read, d_waitrequest);
        end
    endtask

    initial begin
        clear_req();
        rst_n = 1'b0;
        test_reset();
        test_fetch();
        test_store();
        test_back_to_back();
        test_stall();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
